// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl.sv
// IJTAG-controlled data-mux select with a quiesce handshake to the functional source.
// Define TESSENT_DATA_MUX_CTRL_ACK_SYNC_EN to pass func_quiesce_ack through a 2-flop synchronizer.
module firebird7_in_gate1_tessent_data_mux_ctrl #(
  parameter int TIMEOUT_W = 8
) (
  input  logic ijtag_tck,
  input  logic ijtag_reset,
  input  logic ijtag_sel,
  input  logic ijtag_se,
  input  logic ijtag_ce,
  input  logic ijtag_ue,
  input  logic ijtag_si,
  output logic ijtag_so,
  output logic func_quiesce_req,
  input  logic func_quiesce_ack,
  output logic ijtag_select,
  output logic timeout_flag
);

  // state | meaning
  // FUNC  | functional data selected, idle
  // REQ   | quiesce requested, waiting for ack or timeout
  // IJTAG | IJTAG data selected
  // REL   | releasing, waiting for ack to drop
  localparam logic [1:0] ST_FUNC  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_IJTAG = 2'd2;
  localparam logic [1:0] ST_REL   = 2'd3;

  localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;
  localparam logic [TIMEOUT_W-1:0] CNT_ONE = TIMEOUT_W'(1);

  logic [1:0]           state_q, state_d;
  logic [1:0]           sr_q, sr_d;
  logic                 upd_req_q, upd_req_d;
  logic                 upd_force_q, upd_force_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 select_q, select_d;
  logic                 qreq_q, qreq_d;
  logic                 tflag_q, tflag_d;
  logic                 ack_s;
  logic                 upd_fire;

`ifdef TESSENT_DATA_MUX_CTRL_ACK_SYNC_EN
  logic [1:0] ack_sync_q;

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) ack_sync_q <= 2'b00;
    else              ack_sync_q <= {ack_sync_q[0], func_quiesce_ack};
  end

  assign ack_s = ack_sync_q[1];
`else
  assign ack_s = func_quiesce_ack;
`endif

  assign upd_fire = ijtag_sel & ijtag_ue;

  always_comb begin
    sr_d        = sr_q;
    upd_req_d   = upd_req_q;
    upd_force_d = upd_force_q;
    if (ijtag_sel & ijtag_ce & ijtag_se)       sr_d = {ijtag_si, sr_q[1]};
    else if (ijtag_sel & ijtag_ce & !ijtag_se) sr_d = {select_q, tflag_q};
    if (upd_fire) begin
      upd_req_d   = sr_q[1];
      upd_force_d = sr_q[0];
    end
  end

  // Outputs are computed alongside the next state so they come straight from flops.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    select_d = select_q;
    qreq_d   = qreq_q;
    tflag_d  = tflag_q;
    if (upd_fire && !sr_q[1]) tflag_d = 1'b0;
    case (state_q)
      ST_FUNC: begin
        cnt_d    = '0;
        select_d = 1'b0;
        qreq_d   = 1'b0;
        if (upd_req_q && upd_force_q) begin
          state_d  = ST_IJTAG;
          select_d = 1'b1;
        end else if (upd_req_q && !tflag_q) begin
          state_d = ST_REQ;
          qreq_d  = 1'b1;
          cnt_d   = CNT_ONE;
        end
      end
      ST_REQ: begin
        if (ack_s) begin
          state_d  = ST_IJTAG;
          select_d = 1'b1;
          cnt_d    = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_FUNC;
          qreq_d  = 1'b0;
          tflag_d = 1'b1;
          cnt_d   = '0;
        end else if (!upd_req_q) begin
          state_d = ST_REL;
          qreq_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_IJTAG: begin
        if (!upd_req_q) begin
          state_d  = ST_REL;
          select_d = 1'b0;
          qreq_d   = 1'b0;
        end
      end
      default: begin
        select_d = 1'b0;
        qreq_d   = 1'b0;
        if (!ack_s) state_d = ST_FUNC;
      end
    endcase
  end

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      state_q     <= ST_FUNC;
      sr_q        <= 2'b00;
      upd_req_q   <= 1'b0;
      upd_force_q <= 1'b0;
      cnt_q       <= '0;
      select_q    <= 1'b0;
      qreq_q      <= 1'b0;
      tflag_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      upd_req_q   <= upd_req_d;
      upd_force_q <= upd_force_d;
      cnt_q       <= cnt_d;
      select_q    <= select_d;
      qreq_q      <= qreq_d;
      tflag_q     <= tflag_d;
    end
  end

  assign ijtag_so         = sr_q[0];
  assign ijtag_select     = select_q;
  assign func_quiesce_req = qreq_q;
  assign timeout_flag     = tflag_q;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_ctrl.sv
// Bench for the IJTAG data-mux controller: directed handshake scenarios plus random traffic
// against a behavioural model of the select/quiesce protocol.
module tb_firebird7_in_gate1_tessent_data_mux_ctrl;
  localparam int TW = 4;
  localparam int TMAX = (1 << TW) - 1;
`ifdef TESSENT_DATA_MUX_CTRL_ACK_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic ijtag_tck, ijtag_reset;
  logic ijtag_sel, ijtag_se, ijtag_ce, ijtag_ue, ijtag_si;
  logic ijtag_so, func_quiesce_req, func_quiesce_ack, ijtag_select, timeout_flag;

  firebird7_in_gate1_tessent_data_mux_ctrl #(.TIMEOUT_W(TW)) dut (
    .ijtag_tck        (ijtag_tck),
    .ijtag_reset      (ijtag_reset),
    .ijtag_sel        (ijtag_sel),
    .ijtag_se         (ijtag_se),
    .ijtag_ce         (ijtag_ce),
    .ijtag_ue         (ijtag_ue),
    .ijtag_si         (ijtag_si),
    .ijtag_so         (ijtag_so),
    .func_quiesce_req (func_quiesce_req),
    .func_quiesce_ack (func_quiesce_ack),
    .ijtag_select     (ijtag_select),
    .timeout_flag     (timeout_flag)
  );

  initial ijtag_tck = 1'b0;
  always #5 ijtag_tck = ~ijtag_tck;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // Model: mode 0=functional, 1=requesting, 2=ijtag, 3=releasing
  int       m_mode;
  bit       m_forced;
  int       m_age;
  bit [1:0] m_sr;
  bit       m_ureq, m_uforce, m_tf;
  bit       m_ah0, m_ah1;

  function automatic bit m_sel_o();
    return m_mode == 2;
  endfunction

  function automatic bit m_qreq_o();
    return (m_mode == 1) || (m_mode == 2 && !m_forced);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_forced = 0; m_age = 0; m_sr = 2'b00;
    m_ureq = 0; m_uforce = 0; m_tf = 0; m_ah0 = 0; m_ah1 = 0;
  endtask

  task automatic model_tick();
    bit       ack_seen, o_sel, o_ureq, o_uforce, o_tf;
    bit [1:0] o_sr;
    if (!ijtag_reset) begin
      model_reset();
      return;
    end
    ack_seen = (LAT == 0) ? func_quiesce_ack : m_ah1;
    o_sel = m_sel_o(); o_sr = m_sr; o_ureq = m_ureq; o_uforce = m_uforce; o_tf = m_tf;
    if (ijtag_sel && ijtag_ce && ijtag_se) m_sr = {ijtag_si, o_sr[1]};
    else if (ijtag_sel && ijtag_ce)        m_sr = {o_sel, o_tf};
    if (ijtag_sel && ijtag_ue) begin
      m_ureq = o_sr[1];
      m_uforce = o_sr[0];
      if (!o_sr[1]) m_tf = 0;
    end
    case (m_mode)
      0: if (o_ureq && o_uforce) begin m_mode = 2; m_forced = 1; end
         else if (o_ureq && !o_tf) begin m_mode = 1; m_age = 1; end
      1: if (ack_seen) begin m_mode = 2; m_forced = 0; end
         else if (m_age == TMAX) begin m_mode = 0; m_tf = 1; end
         else if (!o_ureq) m_mode = 3;
         else m_age++;
      2: if (!o_ureq) m_mode = 3;
      default: if (!ack_seen) m_mode = 0;
    endcase
    m_ah1 = m_ah0;
    m_ah0 = func_quiesce_ack;
  endtask

  task automatic step();
    @(posedge ijtag_tck);
    #1;
    model_tick();
    chk("so", int'(ijtag_so), int'(m_sr[0]));
    chk("qreq", int'(func_quiesce_req), int'(m_qreq_o()));
    chk("select", int'(ijtag_select), int'(m_sel_o()));
    chk("tflag", int'(timeout_flag), int'(m_tf));
  endtask

  task automatic shift_update(input bit req, input bit frc);
    ijtag_sel = 1; ijtag_se = 1; ijtag_ce = 1; ijtag_ue = 0;
    ijtag_si = frc; step();
    ijtag_si = req; step();
    ijtag_se = 0; ijtag_ce = 0; ijtag_ue = 1; step();
    ijtag_ue = 0; ijtag_sel = 0; ijtag_si = 0;
  endtask

  task automatic capture();
    ijtag_sel = 1; ijtag_ce = 1; ijtag_se = 0; step();
    ijtag_ce = 0; ijtag_sel = 0;
  endtask

  task automatic async_reset_check(input string tag);
    #2 ijtag_reset = 0;
    #1;
    model_reset();
    chk({tag, "_sel"}, int'(ijtag_select), 0);
    chk({tag, "_qreq"}, int'(func_quiesce_req), 0);
    chk({tag, "_so"}, int'(ijtag_so), 0);
    chk({tag, "_tflag"}, int'(timeout_flag), 0);
    step();
    ijtag_reset = 1;
    step();
  endtask

  initial begin
    int n, qh, sh;
    ijtag_reset = 0; ijtag_sel = 0; ijtag_se = 0; ijtag_ce = 0; ijtag_ue = 0;
    ijtag_si = 0; func_quiesce_ack = 0;
    model_reset();
    step(); step();
    chk("reset_sel", int'(ijtag_select), 0);
    chk("reset_qreq", int'(func_quiesce_req), 0);
    ijtag_reset = 1;
    step();

    // Request with ack arriving 3 cycles after quiesce request
    shift_update(1, 0);
    n = 0;
    while (!m_qreq_o() && n < 10) begin step(); n++; end
    chk("req_seen", int'(func_quiesce_req), 1);
    step(); step();
    func_quiesce_ack = 1;
    n = 0;
    while (!ijtag_select && n < 10) begin step(); n++; end
    chk("ack_to_sel", n, LAT + 1);
    capture();
    chk("cap_bit0", int'(ijtag_so), 0);
    ijtag_sel = 1; ijtag_se = 1; ijtag_ce = 1; ijtag_si = 0; step();
    ijtag_sel = 0; ijtag_se = 0; ijtag_ce = 0;
    chk("cap_bit1", int'(ijtag_so), 1);

    // Release with ack still high for 5 cycles
    shift_update(0, 0);
    repeat (5) step();
    func_quiesce_ack = 0;
    repeat (LAT + 3) step();

    // Timeout with ack held low
    shift_update(1, 0);
    qh = 0; sh = 0;
    repeat (25) begin step(); qh += int'(func_quiesce_req); sh += int'(ijtag_select); end
    chk("to_qreq_cycles", qh, TMAX);
    chk("to_sel_cycles", sh, 0);
    chk("to_flag", int'(timeout_flag), 1);
    shift_update(1, 0);
    qh = 0;
    repeat (5) begin step(); qh += int'(func_quiesce_req); end
    chk("to_ignored", qh, 0);
    capture();
    chk("cap_flag", int'(ijtag_so), 1);
    shift_update(0, 0);
    step();
    chk("to_cleared", int'(timeout_flag), 0);

    // Forced entry: no quiesce request
    shift_update(1, 1);
    step();
    chk("force_sel", int'(ijtag_select), 1);
    qh = 0;
    repeat (5) begin step(); qh += int'(func_quiesce_req); end
    chk("force_noqreq", qh, 0);
    shift_update(0, 0);
    step();
    chk("force_rel", int'(ijtag_select), 0);
    repeat (3) step();

    // Reset mid-handshake, then reset while in IJTAG
    shift_update(1, 0);
    repeat (3) step();
    async_reset_check("rst_req");
    shift_update(1, 1);
    step(); step();
    chk("pre_rst_sel", int'(ijtag_select), 1);
    async_reset_check("rst_ijtag");

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      ijtag_sel = ($urandom_range(0, 3) != 0);
      ijtag_se  = $urandom_range(0, 1) == 1;
      ijtag_ce  = $urandom_range(0, 1) == 1;
      ijtag_ue  = $urandom_range(0, 5) == 0;
      ijtag_si  = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 5) == 0) func_quiesce_ack = ~func_quiesce_ack;
      ijtag_reset = ($urandom_range(0, 199) != 0);
      step();
    end
    ijtag_reset = 1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
